// File: rtl/game_retract_if.sv
// game_retract_if: command/state bundle between the move logic and the retract engine.
// Macro: none.
// Ports (master = move/level logic, slave = game_retract):
//   game_state_en   command strobe
//   sel             0 load, 1 commit, 2 retract, 3 hold
//   game_state_int  initial level state
//   game_state_bm   state before the committed move
//   game_state_mm   state after the committed move
//   game_state      current registered game state
//   hist_cnt        number of valid history entries
//   can_retract     history non-empty
interface game_retract_if #(
    parameter int STATE_W = 134,
    parameter int PTR_W   = 4
);
    logic               game_state_en;
    logic [1:0]         sel;
    logic [STATE_W-1:0] game_state_int;
    logic [STATE_W-1:0] game_state_bm;
    logic [STATE_W-1:0] game_state_mm;
    logic [STATE_W-1:0] game_state;
    logic [PTR_W:0]     hist_cnt;
    logic               can_retract;

    modport master (
        output game_state_en, sel, game_state_int, game_state_bm, game_state_mm,
        input  game_state, hist_cnt, can_retract
    );

    modport slave (
        input  game_state_en, sel, game_state_int, game_state_bm, game_state_mm,
        output game_state, hist_cnt, can_retract
    );
endinterface

// File: rtl/game_retract.sv
// game_retract: undo engine holding the current game state and a LIFO of pre-move states.
// Macro: GAME_RETRACT_OVERWRITE_EN - when defined, a commit on a full history drops the oldest entry.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  game_retract_if.slave (command strobe/select, level/move data, state and history status)
module game_retract #(
    parameter int STATE_W = 134,
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4
) (
    input logic           clk,
    input logic           rst,
    game_retract_if.slave bus
);
`ifdef GAME_RETRACT_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [STATE_W-1:0] mem [DEPTH];
    logic [STATE_W-1:0] state;
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   top;
    logic [PTR_W:0]     cnt;
    logic [PTR_W:0]     cnt_nxt;
    logic               can;
    logic               load;
    logic               commit;
    logic               push;
    logic               pop;
    logic               full;

    assign full   = cnt == FULL;
    assign top    = wp - 1'b1;
    assign load   = bus.game_state_en && bus.sel == 2'd0;
    assign commit = bus.game_state_en && bus.sel == 2'd1;
    assign pop    = bus.game_state_en && bus.sel == 2'd2 && cnt != '0;
    // A full history only accepts a push when the oldest entry may be overwritten.
    assign push   = commit && (!full || OVERWRITE);

    always_comb begin
        cnt_nxt = load ? '0 : (push && !full) ? cnt + 1'b1 : pop ? cnt - 1'b1 : cnt;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= bus.game_state_bm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
            wp    <= '0;
            cnt   <= '0;
            can   <= 1'b0;
        end else begin
            state <= load ? bus.game_state_int : commit ? bus.game_state_mm : pop ? mem[top] : state;
            wp    <= push ? wp + 1'b1 : pop ? top : wp;
            cnt   <= cnt_nxt;
            can   <= cnt_nxt != '0;
        end
    end

    assign bus.game_state  = state;
    assign bus.hist_cnt    = cnt;
    assign bus.can_retract = can;
endmodule

// File: tb/tb_game_retract.sv
// tb_game_retract: randomized scoreboard bench for game_retract against a queue-based undo model.
module tb_game_retract;
    localparam int STATE_W = 134;
    localparam int DEPTH   = 16;
    localparam int PTR_W   = 4;
`ifdef GAME_RETRACT_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    typedef struct {
        logic [STATE_W-1:0] st;
        int                 cnt;
        bit                 can;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    exp_t               exp_q[$];
    exp_t               got;
    logic [STATE_W-1:0] m_state;
    logic [STATE_W-1:0] m_hist[$];

    game_retract_if #(.STATE_W(STATE_W), .PTR_W(PTR_W)) bus ();

    game_retract #(.STATE_W(STATE_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [STATE_W-1:0] mk(input int tag, input logic [127:0] map);
        logic [5:0] t;
        t = 6'(tag);
        return {t, map};
    endfunction

    function automatic logic [STATE_W-1:0] rnd();
        return STATE_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // Drives one cycle of stimulus and records what the undo rules say must follow it.
    task automatic step(input bit r, input bit e, input logic [1:0] s,
                        input logic [STATE_W-1:0] i, input logic [STATE_W-1:0] b,
                        input logic [STATE_W-1:0] m);
        exp_t x;
        @(negedge clk);
        rst = r;
        bus.game_state_en  = e;
        bus.sel            = s;
        bus.game_state_int = i;
        bus.game_state_bm  = b;
        bus.game_state_mm  = m;
        if (r) begin
            m_state = '0;
            m_hist.delete();
        end else if (e && s == 2'd0) begin
            m_state = i;
            m_hist.delete();
        end else if (e && s == 2'd1) begin
            m_state = m;
            if (m_hist.size() < DEPTH) m_hist.push_back(b);
            else if (OVW) begin
                void'(m_hist.pop_front());
                m_hist.push_back(b);
            end
        end else if (e && s == 2'd2 && m_hist.size() > 0) begin
            m_state = m_hist.pop_back();
        end
        x.st  = m_state;
        x.cnt = m_hist.size();
        x.can = m_hist.size() != 0;
        exp_q.push_back(x);
    endtask

    task automatic cmd(input logic [1:0] s, input logic [STATE_W-1:0] b, input logic [STATE_W-1:0] m);
        step(1'b0, 1'b1, s, rnd(), b, m);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            checks += 3;
            if (bus.game_state !== got.st) begin
                failures++;
                $display("FAIL game_state got=%h exp=%h", bus.game_state, got.st);
            end
            if (int'(bus.hist_cnt) != got.cnt || $isunknown(bus.hist_cnt)) begin
                failures++;
                $display("FAIL hist_cnt got=%0d exp=%0d", bus.hist_cnt, got.cnt);
            end
            if (bus.can_retract !== got.can) begin
                failures++;
                $display("FAIL can_retract got=%b exp=%b", bus.can_retract, got.can);
            end
        end
    end

    initial begin
        logic [127:0] ones;
        logic [127:0] ints;
        ones = '1;
        ints = {32{4'h1}};
        rst = 1'b1;
        bus.game_state_en = 1'b0;
        bus.sel = 2'd3;
        bus.game_state_int = '0;
        bus.game_state_bm = '0;
        bus.game_state_mm = '0;
        step(1'b1, 1'b0, 2'd3, rnd(), rnd(), rnd());
        step(1'b0, 1'b1, 2'd0, mk(0, ints), rnd(), rnd());
        cmd(2'd1, mk(1, ones), mk(2, ones));
        cmd(2'd2, rnd(), rnd());
        step(1'b0, 1'b0, 2'd1, rnd(), mk(3, ones), mk(4, ones));
        cmd(2'd1, mk(3, ones), mk(4, ones));
        cmd(2'd2, rnd(), rnd());
        repeat (6) cmd(2'd3, rnd(), rnd());
        cmd(2'd2, rnd(), rnd());
        cmd(2'd2, rnd(), rnd());
        for (int k = 1; k <= DEPTH + 1; k++) cmd(2'd1, mk(k - 1, ones), mk(k, ones));
        for (int k = 0; k <= DEPTH; k++) cmd(2'd2, rnd(), rnd());
        for (int k = 1; k <= 3; k++) cmd(2'd1, mk(k - 1, ints), mk(k, ints));
        step(1'b0, 1'b1, 2'd0, mk(9, ints), rnd(), rnd());
        cmd(2'd2, rnd(), rnd());
        cmd(2'd1, rnd(), rnd());
        step(1'b1, 1'b1, 2'd1, rnd(), rnd(), rnd());
        cmd(2'd2, rnd(), rnd());
        for (int n = 0; n < 400; n++) begin
            int w;
            logic [1:0] s;
            w = $urandom_range(0, 99);
            s = (n < 200) ? ((w < 70) ? 2'd1 : 2'(w % 4)) : ((w < 55) ? 2'd2 : 2'(w % 4));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, s, rnd(), rnd(), rnd());
        end
        @(negedge clk);
        bus.game_state_en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_retract.md
Name: game_retract

Overview:
- Undo ("retract") engine for the Sokoban game core.
- Holds the current 134-bit game state and a LIFO history of pre-move states.
- Loads the initial level, commits moves supplied by the move logic, and restores the previous state on a retract request.
- Sits between the move/level logic and the renderer; the renderer consumes `game_state`.

Parameters:
- STATE_W, 134, total state width (6-bit tag/status field in [133:128] plus 128-bit map in [127:0]); treated as opaque data.
- DEPTH, 16, number of retractable moves held in history (power of two, >=2).
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- game_state_en  input  1  command strobe; command executes only on a cycle where this is 1.
- sel  input  2  command select: 0 = load initial, 1 = commit move, 2 = retract, 3 = hold.
- game_state_int  input  STATE_W  initial level state.
- game_state_bm  input  STATE_W  state before the move being committed.
- game_state_mm  input  STATE_W  state after the move being committed.
- game_state  output  STATE_W  current registered game state.
- hist_cnt  output  PTR_W+1  number of valid history entries (0..DEPTH).
- can_retract  output  1  high when hist_cnt != 0.

Behaviour:
- Reset (rst=1 at a rising edge; overrides everything else):
  - game_state <= 0; hist_cnt <= 0; stack pointer <= 0; can_retract <= 0.
  - History RAM contents need not be cleared.
- game_state_en=0: no state change regardless of sel or data inputs.
- sel=0, en=1: game_state <= game_state_int; history emptied (hist_cnt <= 0).
- sel=1, en=1:
  - game_state <= game_state_mm.
  - game_state_bm pushed onto the history top; hist_cnt increments.
- sel=2, en=1:
  - If hist_cnt>0: game_state <= top history entry; entry popped; hist_cnt decrements.
  - If hist_cnt=0: no change (retract on empty is a silent no-op).
- sel=3, en=1: hold; no change.
- Latency: all commands take effect in one cycle; game_state reflects the command on the edge where en=1 is sampled.
- Back-to-back commands on consecutive cycles are legal and each executes.
- Holding en=1 with sel=1 or sel=2 repeats the command every cycle; the bench and system strobe en for one cycle per action.
- History storage:
  - Circular buffer of DEPTH entries with a write pointer; top = wp-1 (mod DEPTH).
  - Push writes at wp, then wp <= wp+1 (wrap mod DEPTH).
  - Pop reads at wp-1, then wp <= wp-1.
  - The pop output is the registered restored value, not a combinational path.
- Full boundary (hist_cnt=DEPTH) with a commit: governed by the optional feature below.
- Data inputs are sampled only on executing cycles; their values at other times are don't-care.
- can_retract and hist_cnt are registered and updated on the same edge as game_state.

Optional Feature:
- Macro: GAME_RETRACT_OVERWRITE_EN.
- Defined: a commit when full overwrites the oldest entry. wp advances and wraps, hist_cnt stays at DEPTH, and the most recent DEPTH moves stay retractable.
- Undefined: a commit when full still updates game_state <= game_state_mm but does not push. History and hist_cnt stay unchanged, so the newest move is not retractable.
- In both cases game_state behaviour for sel=0/2/3 is identical.

Test Plan:
- rst=1 one cycle -> game_state=0, hist_cnt=0, can_retract=0.
- int={6'd0,128'h1..1}; sel=0,en=1 -> game_state=int, hist_cnt=0. Then sel=1,en=1 with mm={6'd2,1s}, bm={6'd1,1s} -> game_state[133:128]=2, hist_cnt=1. Then sel=2,en=1 -> game_state[133:128]=1, hist_cnt=0.
- en=0 with sel=1 and new mm={6'd4,..}, bm={6'd3,..} -> no change. Then en=1 -> tag=4, hist_cnt=1. Then sel=2 -> tag=3. Then sel=3,en=1 for 6 cycles -> tag stays 3.
- Retract on empty: hist_cnt=0, sel=2,en=1 -> game_state unchanged, hist_cnt=0.
- Commit tags 1..DEPTH+1 (bm tag = k-1) then DEPTH+1 retracts:
  - With GAME_RETRACT_OVERWRITE_EN: restores tags DEPTH..1, last retract is a no-op.
  - Without it: first retract restores DEPTH-1, last retract is a no-op.
- Mid-history reload: 3 commits then sel=0 -> game_state=int, hist_cnt=0. A following retract is a no-op. rst asserted between commit and retract -> game_state=0, hist_cnt=0.
